i2c_target_regs: RTL

- I2C target (slave) port that lets an external I2C controller read and write an 8-bit-addressed register space in the display subsystem, such as VGA timing and mode registers.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address and handles acknowledge.
- Drives SDA open-drain through an output-enable, and presents a simple one-cycle-strobe register bus to the local register file.

---
 rtl/i2c_target_regs.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_target_regs                                           |
// | Desc     : I2C target port giving an external controller read/write  |
// |            access to an 8-bit addressed register space through a    |
// |            one-cycle-strobe register bus. SDA is open-drain (oe).    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2       // must be 2 or more
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    // Protocol states
    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_ADDR     = 4'd1;
    localparam logic [3:0] c_ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] c_ST_PTR      = 4'd3;
    localparam logic [3:0] c_ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] c_ST_WDATA    = 4'd5;
    localparam logic [3:0] c_ST_WACK     = 4'd6;
    localparam logic [3:0] c_ST_RDATA    = 4'd7;
    localparam logic [3:0] c_ST_MACK     = 4'd8;
    localparam logic [3:0] c_ST_IGNORE   = 4'd9;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_ackph;     // second half of an ACK slot (ACK driven / ACK seen)
    logic       r_rw;        // R/W bit of the matched address byte
    logic       r_sda_oe;
    logic       r_busy;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_inc;       // pointer bump owed after a wr/rd strobe

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_rx_state;
    logic       w_count_state;
    logic       w_ack_state;
    logic       w_reg_wr;
    logic       w_reg_rd;

    // Bring SCL/SDA into the clk domain and keep one history sample for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both samples so an SDA move at an SCL edge is not a condition
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_rx_byte     = {r_shift[6:0], w_sda};
    assign w_byte_done   = w_scl_rise && (r_bitcnt == 3'd7);
    assign w_rx_state    = (r_state == c_ST_ADDR) || (r_state == c_ST_PTR) ||
                           (r_state == c_ST_WDATA);
    assign w_count_state = w_rx_state || (r_state == c_ST_RDATA);
    assign w_ack_state   = (r_state == c_ST_ADDR_ACK) || (r_state == c_ST_PTR_ACK) ||
                           (r_state == c_ST_WACK);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; START/STOP override everything
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_ADDR: begin
                    if (w_byte_done) begin
                        w_state_nxt = (w_rx_byte[7:1] == DEV_ADDR) ? c_ST_ADDR_ACK : c_ST_IGNORE;
                    end
                end
                c_ST_ADDR_ACK: begin
                    if (w_scl_fall && r_ackph) begin
                        w_state_nxt = r_rw ? c_ST_RDATA : c_ST_PTR;
                    end
                end
                c_ST_PTR: begin
                    if (w_byte_done) w_state_nxt = c_ST_PTR_ACK;
                end
                c_ST_PTR_ACK: begin
                    if (w_scl_fall && r_ackph) w_state_nxt = c_ST_WDATA;
                end
                c_ST_WDATA: begin
                    if (w_byte_done) w_state_nxt = c_ST_WACK;
                end
                c_ST_WACK: begin
                    if (w_scl_fall && r_ackph) w_state_nxt = c_ST_WDATA;
                end
                c_ST_RDATA: begin
                    if (w_byte_done) w_state_nxt = c_ST_MACK;
                end
                c_ST_MACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt = c_ST_IGNORE;
                    end else if (w_scl_fall && r_ackph) begin
                        w_state_nxt = c_ST_RDATA;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Register-bus strobes: write on the ACK-drive fall, fetch when a read byte starts
    always_comb begin
        w_reg_wr = 1'b0;
        w_reg_rd = 1'b0;
        if (w_scl_fall) begin
            if ((r_state == c_ST_WACK) && !r_ackph) begin
                w_reg_wr = 1'b1;
            end
            if (r_ackph && (((r_state == c_ST_ADDR_ACK) && r_rw) || (r_state == c_ST_MACK))) begin
                w_reg_rd = 1'b1;
            end
        end
    end

    // Bit counter, ACK phase, shift register and R/W capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitcnt <= 3'd0;
            r_ackph  <= 1'b0;
            r_shift  <= 8'h00;
            r_rw     <= 1'b0;
        end else begin
            if (w_start || w_stop || (w_state_nxt != r_state)) begin
                r_bitcnt <= 3'd0;
                r_ackph  <= 1'b0;
            end else begin
                if (w_scl_rise && w_count_state) r_bitcnt <= r_bitcnt + 3'd1;
                if (w_scl_fall && w_ack_state) r_ackph <= 1'b1;
                if (w_scl_rise && (r_state == c_ST_MACK) && !w_sda) r_ackph <= 1'b1;
            end

            if (w_reg_rd) begin
                r_shift <= reg_rdata;
            end else if (w_scl_rise && w_rx_state) begin
                r_shift <= w_rx_byte;
            end else if (w_scl_fall && (r_state == c_ST_RDATA)) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end

            if ((r_state == c_ST_ADDR) && w_byte_done) r_rw <= w_sda;
        end
    end

    // SDA drive and busy flag; SDA only moves on an SCL fall except when released by START/STOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_stop) r_busy <= 1'b0;
            if (w_start || w_stop) begin
                r_sda_oe <= 1'b0;
            end else if (w_scl_fall) begin
                case (r_state)
                    c_ST_ADDR_ACK, c_ST_PTR_ACK, c_ST_WACK: begin
                        if (!r_ackph) begin
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_sda_oe <= w_reg_rd ? ~reg_rdata[7] : 1'b0;
                        end
                    end
                    c_ST_RDATA: r_sda_oe <= ~r_shift[6];
                    c_ST_MACK:  r_sda_oe <= w_reg_rd ? ~reg_rdata[7] : 1'b0;
                    default:    r_sda_oe <= 1'b0;
                endcase
                if ((r_state == c_ST_ADDR_ACK) && !r_ackph) r_busy <= 1'b1;
            end
        end
    end

    // Register pointer and write data; pointer bumps the cycle after each strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_inc       <= 1'b0;
        end else begin
            r_inc <= w_reg_wr | w_reg_rd;
            if ((r_state == c_ST_PTR_ACK) && w_scl_fall && r_ackph) begin
                r_reg_addr <= r_shift;
            end else if (r_inc) begin
                r_reg_addr <= r_reg_addr + 8'd1;
            end
            if ((r_state == c_ST_WDATA) && w_byte_done) begin
                r_reg_wdata <= w_rx_byte;
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = w_reg_wr;
    assign reg_rd    = w_reg_rd;

endmodule
`default_nettype wire
